// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: pipeline-control types and constants shared by the hazard unit
package riscv_pipe_pkg;
    localparam int REG_ADDR_W = 5;
    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} hz_state_e;
endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: event counter that sticks at all-ones instead of wrapping
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, redirects and multi-cycle ops
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  ex_mc_start,
    input  logic                  mc_done,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_stall,
    output logic                  idex_flush,
    output logic                  exmem_bubble,
    output logic                  mc_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);
    localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);
    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              load_use, redirect, mc_start, timeout_hit, holding, flushing, bubbling;
    // Outputs are gated by rst_n so they drop the instant reset asserts, even mid-wait.
    always_comb begin
        load_use    = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        redirect    = ex_valid & ex_redirect;
        mc_start    = ex_valid & ex_mc_start & ~mc_done;
        timeout_hit = (state_q == MC_WAIT) & ~mc_done & (wait_q == WAIT_W'(MC_TIMEOUT - 1));
        holding     = (state_q == MC_WAIT) ? (~mc_done & ~timeout_hit) : (~redirect & mc_start);
        flushing    = (state_q == RUN) & redirect;
        bubbling    = (state_q == RUN) & ~redirect & ~mc_start & load_use;
        state_d     = holding ? MC_WAIT : RUN;
        wait_d      = (state_q == MC_WAIT && holding) ? wait_q + 1'b1 : '0;
        timeout_d   = timeout_q | timeout_hit;
        pc_stall     = rst_n & (holding | bubbling);
        ifid_stall   = rst_n & (holding | bubbling);
        ifid_flush   = rst_n & flushing;
        idex_stall   = rst_n & holding;
        idex_flush   = rst_n & (flushing | bubbling);
        exmem_bubble = rst_n & holding;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
    assign mc_timeout = timeout_q;
    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall),
        .count (stall_cycles)
    );
    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_events)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus hand sequences for multi-cycle, timeout, reset and saturation
module tb_hazard_ctrl;
    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_LU   = 6'b110010;
    localparam logic [5:0] E_FL   = 6'b001010;
    localparam logic [5:0] E_MC   = 6'b110101;

    typedef struct {
        string      name;
        logic       idv;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic [4:0] rd;
        logic       mr;
        logic       rdr;
        logic       mcs;
        logic       mcd;
        logic [5:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_mem_read, ex_redirect, ex_mc_start, mc_done;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble, mc_timeout;
    logic [3:0] stall_cycles, flush_events;
    logic [5:0] outs;

    int         tests = 0;
    int         failed = 0;
    logic [5:0] exp_q[$];
    string      name_q[$];

    hazard_ctrl #(.REG_ADDR_W(5), .MC_TIMEOUT(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .ex_mc_start  (ex_mc_start),
        .mc_done      (mc_done),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_stall   (idex_stall),
        .idex_flush   (idex_flush),
        .exmem_bubble (exmem_bubble),
        .mc_timeout   (mc_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;
    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble};

    function automatic vec_t mk(string n, logic idv, logic [4:0] r1, logic [4:0] r2, logic u1,
                                logic u2, logic exv, logic [4:0] rd, logic mr, logic rdr,
                                logic mcs, logic mcd, logic [5:0] e);
        vec_t v;
        v.name = n; v.idv = idv; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.rd = rd; v.mr = mr; v.rdr = rdr; v.mcs = mcs; v.mcd = mcd; v.exp = e;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic set_in(vec_t v);
        id_valid = v.idv; id_rs1 = v.r1; id_rs2 = v.r2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_valid = v.exv; ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.rdr;
        ex_mc_start = v.mcs; mc_done = v.mcd;
    endtask

    task automatic sb_check();
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            logic [5:0] e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {26'd0, outs}, {26'd0, e});
        end
    endtask

    task automatic step(vec_t v);
        @(posedge clk);
        #1;
        set_in(v);
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        sb_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[12];
    vec_t idle, lu, mcw, fl;
    int   exp_stall, exp_flush;

    initial begin
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
        lu   = mk("ld_use_sat", 1, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, E_LU);
        fl   = mk("redir_sat", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, E_FL);
        mcw  = mk("mc_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_MC);

        rst_n = 1'b0;
        set_in(lu);
        #2;
        check("rst_outs", {26'd0, outs}, 32'd0);
        check("rst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
        check("rst_flush_cnt", {28'd0, flush_events}, 32'd0);
        check("rst_timeout", {31'd0, mc_timeout}, 32'd0);
        @(negedge clk);
        set_in(idle);
        rst_n = 1'b1;

        tbl[0]  = mk("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
        tbl[1]  = mk("ld_use_rs2",   1, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, E_LU);
        tbl[2]  = mk("ld_x0",        1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, E_NONE);
        tbl[3]  = mk("redir_ld_use", 1, 1, 5, 1, 1, 1, 5, 1, 1, 0, 0, E_FL);
        tbl[4]  = mk("ld_use_rs1",   1, 7, 2, 1, 0, 1, 7, 1, 0, 0, 0, E_LU);
        tbl[5]  = mk("rs1_unused",   1, 7, 2, 0, 1, 1, 7, 1, 0, 0, 0, E_NONE);
        tbl[6]  = mk("id_invalid",   0, 7, 7, 1, 1, 1, 7, 1, 0, 0, 0, E_NONE);
        tbl[7]  = mk("ex_invalid",   1, 7, 7, 1, 1, 0, 7, 1, 1, 1, 0, E_NONE);
        tbl[8]  = mk("not_load",     1, 7, 7, 1, 1, 1, 7, 0, 0, 0, 0, E_NONE);
        tbl[9]  = mk("mc_with_done", 1, 3, 3, 1, 1, 1, 3, 1, 0, 1, 1, E_LU);
        tbl[10] = mk("redir_mc",     0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, E_FL);
        tbl[11] = mk("redir_only",   0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, E_FL);
        exp_stall = 0;
        exp_flush = 0;
        foreach (tbl[i]) begin
            step(tbl[i]);
            exp_stall += int'(tbl[i].exp[5]);
            exp_flush += int'(tbl[i].exp[3]);
        end
        step(idle);
        check("tbl_stall_cnt", {28'd0, stall_cycles}, exp_stall);
        check("tbl_flush_cnt", {28'd0, flush_events}, exp_flush);

        do_reset();
        step(mk("mc_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, E_MC));
        step(mk("mc_wait_ignore1", 1, 3, 0, 1, 0, 1, 3, 1, 1, 0, 0, E_MC));
        step(mk("mc_wait_ignore2", 1, 3, 0, 1, 0, 1, 3, 1, 1, 0, 0, E_MC));
        step(mcw);
        step(mk("mc_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE));
        step(mk("run_after_mc", 1, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, E_LU));
        step(idle);
        check("mc_stall_cnt", {28'd0, stall_cycles}, 32'd5);
        check("mc_flush_cnt", {28'd0, flush_events}, 32'd0);
        check("mc_no_timeout", {31'd0, mc_timeout}, 32'd0);

        do_reset();
        step(mk("to_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, E_MC));
        for (int i = 0; i < 7; i++) step(mcw);
        step(mk("to_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        step(mk("after_to", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        check("to_flag", {31'd0, mc_timeout}, 32'd1);
        check("to_stall_cnt", {28'd0, stall_cycles}, 32'd8);
        for (int i = 0; i < 3; i++) step(idle);
        check("to_sticky", {31'd0, mc_timeout}, 32'd1);

        step(mk("rst_mc_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, E_MC));
        step(mcw);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {26'd0, outs}, 32'd0);
        check("midrst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
        check("midrst_timeout", {31'd0, mc_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk("post_rst_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        step(mk("post_rst_ld_use", 1, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, E_LU));

        do_reset();
        for (int i = 0; i < 20; i++) step(lu);
        step(idle);
        check("sat_stall_cnt", {28'd0, stall_cycles}, 32'd15);
        for (int i = 0; i < 20; i++) step(fl);
        step(idle);
        check("sat_flush_cnt", {28'd0, flush_events}, 32'd15);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- REG_ADDR_W, 5, register-index width
- MC_TIMEOUT, 64, max MC_WAIT cycles before forced release
- CNT_W, 16, perf-counter width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- id_valid, in, 1, decode-stage instruction valid
- id_rs1, id_rs2, in, REG_ADDR_W, decode source indices
- id_uses_rs1, id_uses_rs2, in, 1, source actually read
- ex_valid, in, 1, execute-stage instruction valid
- ex_rd, in, REG_ADDR_W, execute destination index
- ex_mem_read, in, 1, execute instruction is a load
- ex_redirect, in, 1, branch/jump taken, resolved in execute
- ex_mc_start, in, 1, multi-cycle op (mul/div) entering execute this cycle
- mc_done, in, 1, multi-cycle unit result ready
- pc_stall, out, 1, hold PC
- ifid_stall, out, 1, hold fetch/decode register
- ifid_flush, out, 1, squash fetch/decode register
- idex_stall, out, 1, hold decode/execute register
- idex_flush, out, 1, load bubble (control signal = 0) into decode/execute register
- exmem_bubble, out, 1, load bubble into execute/memory register
- mc_timeout, out, 1, sticky: multi-cycle timeout occurred
- stall_cycles, out, CNT_W, saturating count of cycles with pc_stall=1
- flush_events, out, CNT_W, saturating count of redirect flushes

Function
REQ-003 SHALL implement FSM states RUN and MC_WAIT; all stall/flush outputs combinational from state and current inputs (zero-latency).
REQ-004 load_use SHALL be ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-005 In RUN, redirect = ex_valid & ex_redirect SHALL assert ifid_flush=1, idex_flush=1, others 0, increment flush_events; state stays RUN.
REQ-006 In RUN without redirect, load_use SHALL assert pc_stall=1, ifid_stall=1, idex_flush=1 for exactly that cycle; state stays RUN.
REQ-007 Priority in RUN: redirect > multi-cycle start > load_use; redirect with load_use SHALL flush, not stall.
REQ-008 In RUN, ex_valid & ex_mc_start & ~mc_done & ~ex_redirect SHALL assert pc_stall, ifid_stall, idex_stall, exmem_bubble that cycle and go MC_WAIT; wait counter cleared.
REQ-009 ex_mc_start with mc_done same cycle SHALL produce no stall and remain RUN.
REQ-010 In MC_WAIT with mc_done=0, SHALL assert pc_stall, ifid_stall, idex_stall, exmem_bubble; ex_redirect and load_use ignored; wait counter increments.
REQ-011 In MC_WAIT with mc_done=1, all stall outputs SHALL be 0 that cycle; next state RUN.
REQ-012 When wait counter reaches MC_TIMEOUT-1 with mc_done=0, SHALL set mc_timeout (sticky until reset), deassert stalls that cycle, return RUN.
REQ-013 stall_cycles SHALL increment each cycle pc_stall=1; both counters saturate at all-ones, no wrap.
REQ-014 No outputs other than counters/mc_timeout SHALL hold state.

Reset
REQ-015 rst_n low SHALL immediately force state RUN, wait counter 0, stall_cycles 0, flush_events 0, mc_timeout 0, and all stall/flush/bubble outputs 0, including mid-MC_WAIT.
REQ-016 After rst_n rises, first active edge SHALL operate per RUN.

Structure
REQ-017 Shared package riscv_pipe_pkg SHALL hold the FSM state enum and REG_ADDR_W constant.
REQ-018 Saturating counter SHALL be one sub-module, hazard_sat_counter, instantiated twice.

Verification
REQ-019 Load x5 in EX, ID uses rs2=x5 -> one cycle pc_stall=ifid_stall=idex_flush=1, stall_cycles=1.
REQ-020 Load to x0, ID rs1=x0 -> no stall.
REQ-021 Redirect plus load_use same cycle -> ifid_flush=idex_flush=1, pc_stall=0, flush_events=1.
REQ-022 mc_start, mc_done after 4 cycles -> stalls high 4 cycles (start + 3 MC_WAIT), low on done cycle, back to RUN.
REQ-023 mc_start, mc_done never, MC_TIMEOUT=8 -> mc_timeout=1 after wait count 7, stalls released, stays 1 until reset.
REQ-024 rst_n low mid-MC_WAIT -> outputs 0 immediately, counters 0, RUN after release.
